// File: rtl/conv_mac_tree.sv
// Multi-tap convolution MAC: signed weight x unsigned pixel products plus bias, pipelined adder
// tree, multi-beat accumulator and saturating output. Define CONV_RELU_EN to clamp negatives to 0.
module conv_mac_tree #(
    parameter int unsigned NUM   = 49,
    parameter int unsigned WEI_W = 16,
    parameter int unsigned IMA_W = 8,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned ACC_W = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [WEI_W*NUM-1:0]   wei,
    input  logic [IMA_W*NUM-1:0]   ima,
    input  logic [WEI_W-1:0]       bias,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat,
    output logic                   seq_err
);
    localparam int unsigned ProdW     = WEI_W + IMA_W + 1;
    localparam int unsigned NumLeaves = NUM + 1;
    localparam int unsigned Depth     = $clog2(NumLeaves);
    localparam int unsigned TreeW     = ProdW + Depth;
    // Pixels are integers, so products carry FRAC + PixFrac fractional bits.
    localparam int unsigned PixFrac   = 0;
    localparam int unsigned BiasAlign = FRAC + PixFrac - FRAC;

    typedef enum logic {StIdle, StBusy} state_e;

    function automatic int unsigned lvl_cnt(input int unsigned lvl);
        int unsigned n;
        n = NumLeaves;
        for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic signed [ProdW-1:0] leaf [NumLeaves];

    always_comb begin
        logic signed [ProdW-1:0] w_ext;
        logic signed [ProdW-1:0] p_ext;
        w_ext = '0;
        p_ext = '0;
        leaf  = '{default: '0};
        for (int k = 0; k < NUM; k++) begin
            w_ext   = ProdW'($signed(wei[k*WEI_W +: WEI_W]));
            p_ext   = ProdW'(ima[k*IMA_W +: IMA_W]);
            leaf[k] = w_ext * p_ext;
        end
        leaf[NUM] = in_first ? (ProdW'($signed(bias)) <<< BiasAlign) : '0;
    end

    // Level 0 is the multiply register; each further level halves the node count.
    for (genvar l = 0; l <= Depth; l++) begin : g_lvl
        localparam int unsigned Cnt = lvl_cnt(l);
        localparam int unsigned W   = ProdW + l;
        logic signed [W-1:0] node [Cnt];

        if (l == 0) begin : g_leaf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) node <= '{default: '0};
                else     node <= leaf;
            end
        end else begin : g_add
            localparam int unsigned PrevCnt = lvl_cnt(l - 1);
            logic signed [W-1:0] sum [Cnt];

            always_comb begin
                sum = '{default: '0};
                for (int i = 0; i < PrevCnt / 2; i++) begin
                    sum[i] = W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
                end
                if (PrevCnt % 2 == 1) sum[Cnt-1] = W'(g_lvl[l-1].node[PrevCnt-1]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) node <= '{default: '0};
                else     node <= sum;
            end
        end
    end

    logic [Depth:0] vld_q, first_q, last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q   <= {vld_q[Depth-1:0], in_valid};
            first_q <= {first_q[Depth-1:0], in_first};
            last_q  <= {last_q[Depth-1:0], in_last};
        end
    end

    logic signed [ACC_W-1:0] tree_sum;
    assign tree_sum = ACC_W'(g_lvl[Depth].node[0]);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    emit_q, emit_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        emit_d  = 1'b0;
        err_d   = 1'b0;
        if (vld_q[Depth]) begin
            if (first_q[Depth]) begin
                // A first beat always restarts; a pending partial sum is a framing error.
                err_d   = (state_q == StBusy);
                acc_d   = tree_sum;
                emit_d  = last_q[Depth];
                state_d = last_q[Depth] ? StIdle : StBusy;
            end else if (state_q == StBusy) begin
                acc_d   = acc_q + tree_sum;
                emit_d  = last_q[Depth];
                state_d = last_q[Depth] ? StIdle : StBusy;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            emit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            emit_q  <= emit_d;
            err_q   <= err_d;
        end
    end

    logic [ACC_W-OUT_W:0] acc_hi;
    logic                 sat_d;
    logic [OUT_W-1:0]     res_d;

    assign acc_hi = acc_q[ACC_W-1:OUT_W-1];

    always_comb begin
        // In range only when every bit above the output sign bit matches it.
        sat_d = !((&acc_hi) || !(|acc_hi));
        res_d = acc_q[OUT_W-1:0];
        if (sat_d) begin
            res_d = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
`ifdef CONV_RELU_EN
        if (res_d[OUT_W-1]) res_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= emit_q;
            seq_err   <= err_q;
            if (emit_q) begin
                out_data <= res_d;
                out_sat  <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_tree.sv
// Bench for conv_mac_tree: a kernel-level model pushes expected results and framing errors,
// tagged with the cycle they must appear, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_conv_mac_tree;
    localparam int NUM   = 49;
    localparam int WEI_W = 16;
    localparam int IMA_W = 8;
    localparam int FRAC  = 8;
    localparam int OUT_W = 16;
    localparam int ACC_W = 40;
    localparam int LAT   = 9;
    localparam longint OMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -OMAX - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [WEI_W*NUM-1:0] wei = '0;
    logic [IMA_W*NUM-1:0] ima = '0;
    logic [WEI_W-1:0]     bias = '0;
    logic                 out_valid, out_sat, seq_err;
    logic [OUT_W-1:0]     out_data;

    conv_mac_tree #(
        .NUM(NUM), .WEI_W(WEI_W), .IMA_W(IMA_W), .FRAC(FRAC), .OUT_W(OUT_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .wei(wei), .ima(ima), .bias(bias), .out_valid(out_valid), .out_data(out_data),
        .out_sat(out_sat), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    int               err_q[$];
    exp_t             mon_e;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    bit               m_busy = 1'b0;
    longint           m_acc = 0;
    logic [OUT_W-1:0] hold_data = '0;
    logic             hold_sat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [WEI_W*NUM-1:0] fill_w(input logic [WEI_W-1:0] v);
        logic [WEI_W*NUM-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*WEI_W +: WEI_W] = v;
        return r;
    endfunction

    function automatic logic [IMA_W*NUM-1:0] fill_i(input logic [IMA_W-1:0] v);
        logic [IMA_W*NUM-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*IMA_W +: IMA_W] = v;
        return r;
    endfunction

    function automatic logic [WEI_W*NUM-1:0] rand_w(input int m);
        logic [WEI_W*NUM-1:0] r;
        int v;
        for (int k = 0; k < NUM; k++) begin
            v = int'($urandom_range(0, 2 * m)) - m;
            r[k*WEI_W +: WEI_W] = WEI_W'(v);
        end
        return r;
    endfunction

    function automatic logic [IMA_W*NUM-1:0] rand_i();
        logic [IMA_W*NUM-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*IMA_W +: IMA_W] = IMA_W'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic longint beat_sum(input logic [WEI_W*NUM-1:0] w,
                                        input logic [IMA_W*NUM-1:0] p,
                                        input logic [WEI_W-1:0] b, input bit f);
        longint s;
        s = 0;
        for (int k = 0; k < NUM; k++) begin
            s += longint'($signed(w[k*WEI_W +: WEI_W])) * longint'(p[k*IMA_W +: IMA_W]);
        end
        if (f) s += longint'($signed(b));
        return s;
    endfunction

    function automatic void push_result(input longint acc);
        exp_t e;
        e.sat  = 1'b0;
        e.data = OUT_W'(acc);
        if (acc > OMAX) begin
            e.data = OUT_W'(OMAX);
            e.sat  = 1'b1;
        end else if (acc < OMIN) begin
            e.data = OUT_W'(OMIN);
            e.sat  = 1'b1;
        end
`ifdef CONV_RELU_EN
        if (e.data[OUT_W-1]) e.data = '0;
`endif
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endfunction

    // Drive one beat and advance the kernel model exactly as the framing rules dictate.
    task automatic send(input bit f, input bit l, input logic [WEI_W*NUM-1:0] w,
                        input logic [IMA_W*NUM-1:0] p, input logic [WEI_W-1:0] b);
        longint s;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        wei      = w;
        ima      = p;
        bias     = b;
        s = beat_sum(w, p, b, f);
        if (f) begin
            if (m_busy) err_q.push_back(cyc + LAT);
            m_acc  = s;
            m_busy = !l;
            if (l) push_result(m_acc);
        end else if (m_busy) begin
            m_acc += s;
            if (l) begin
                push_result(m_acc);
                m_busy = 1'b0;
            end
        end else begin
            err_q.push_back(cyc + LAT);
        end
    endtask

    // Bubbles carry junk data and flags to show they are ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_first = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            wei      = rand_w(100);
            ima      = rand_i();
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        exp_q.delete();
        err_q.delete();
        m_busy    = 1'b0;
        m_acc     = 0;
        hold_data = '0;
        hold_sat  = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        check("rst_seq_err", longint'(seq_err), 0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        bit want_v, want_e;
        if (!rst) begin
            want_v = exp_q.size() > 0 && exp_q[0].cyc == cyc;
            check("out_valid", longint'(out_valid), longint'(want_v));
            if (want_v) begin
                mon_e = exp_q.pop_front();
                check("out_data", longint'(out_data), longint'(mon_e.data));
                check("out_sat", longint'(out_sat), longint'(mon_e.sat));
                hold_data = mon_e.data;
                hold_sat  = mon_e.sat;
            end else if (!out_valid) begin
                check("hold_data", longint'(out_data), longint'(hold_data));
                check("hold_sat", longint'(out_sat), longint'(hold_sat));
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) exp_q.delete(0);

            want_e = err_q.size() > 0 && err_q[0] == cyc;
            check("seq_err", longint'(seq_err), longint'(want_e));
            while (err_q.size() > 0 && err_q[0] <= cyc) err_q.delete(0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        #2;
        check("init_out_valid", longint'(out_valid), 0);
        check("init_out_data", longint'(out_data), 0);
        check("init_out_sat", longint'(out_sat), 0);
        check("init_seq_err", longint'(seq_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // Single beat: 49 * 1.0 + 0.5 = 0x3180.
        send(1, 1, fill_w(16'h0100), fill_i(8'd1), 16'h0080);
        idle(LAT + 3);

        // Positive and negative saturation.
        send(1, 1, fill_w(16'h7FFF), fill_i(8'd255), 16'h7FFF);
        send(1, 1, fill_w(16'h8000), fill_i(8'd255), 16'h8000);
        idle(LAT + 2);

        // Three-beat kernel with bias offered on every beat: 3 * 0x310 + 0x100 = 0x0A30.
        send(1, 0, fill_w(16'h0010), fill_i(8'd1), 16'h0100);
        send(0, 0, fill_w(16'h0010), fill_i(8'd1), 16'h0100);
        send(0, 1, fill_w(16'h0010), fill_i(8'd1), 16'h0100);
        idle(LAT + 2);

        // Back-to-back single-beat kernels with incrementing pixels.
        for (int i = 0; i < 16; i++) begin
            send(1, 1, rand_w(4), fill_i(IMA_W'(i * 16)), WEI_W'($urandom));
        end
        idle(LAT + 2);

        // Framing errors: stray beats in IDLE, then a restart while BUSY.
        send(0, 1, fill_w(16'h0100), fill_i(8'd2), 16'h0000);
        send(0, 0, fill_w(16'h0100), fill_i(8'd2), 16'h0000);
        idle(2);
        send(1, 0, fill_w(16'h0200), fill_i(8'd5), 16'h0300);
        send(1, 0, fill_w(16'h0010), fill_i(8'd1), 16'h0100);
        send(0, 1, fill_w(16'h0010), fill_i(8'd1), 16'h0100);
        idle(LAT + 2);

        // Bubbles inside a kernel.
        send(1, 0, rand_w(8), rand_i(), WEI_W'($urandom));
        idle(2);
        send(0, 0, rand_w(8), rand_i(), WEI_W'($urandom));
        idle(1);
        send(0, 1, rand_w(8), rand_i(), WEI_W'($urandom));

        // Random multi-beat kernels, last and next first often on consecutive cycles.
        for (int kk = 0; kk < 10; kk++) begin
            int nb;
            nb = int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
                send(b == 0, b == nb - 1, rand_w(8), rand_i(), WEI_W'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(LAT + 3);

        // Reset three cycles after the first beat of a two-beat kernel.
        send(1, 0, fill_w(16'h0100), fill_i(8'd3), 16'h0040);
        send(0, 1, fill_w(16'h0100), fill_i(8'd3), 16'h0040);
        idle(1);
        do_reset(2);
        idle(12);

        // Fresh kernel after reset.
        send(1, 0, fill_w(16'h0100), fill_i(8'd1), 16'h0080);
        send(0, 1, fill_w(16'h0020), fill_i(8'd2), 16'h0000);
        idle(LAT + 3);

        check("pending_out", longint'(exp_q.size()), 0);
        check("pending_err", longint'(err_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
